rx_word_assembler: RTL
======================

RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 SHALL have parameter NUM_BITS, default 11; word width is NUM_BITS+1 (12 bits).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in word MSB, 0 = first bit lands in LSB.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port serial_in  input  1  serial data bit, sampled only when bit_valid=1.
REQ-006 SHALL have port bit_valid  input  1  one-cycle strobe per received bit.
REQ-007 SHALL have port frame_start  input  1  one-cycle strobe marking start of a new word.
REQ-008 SHALL have port err_clear  input  1  clears sticky error flags.
REQ-009 SHALL have port word_out  output  NUM_BITS+1  assembled word; drives the downstream word register's data input.
REQ-010 SHALL have port word_load  output  1  one-cycle pulse; drives the downstream register's load enable.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port frame_err  output  1  sticky; set when a word is aborted.
REQ-013 SHALL have port parity_err  output  1  sticky parity failure (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, PARITY (present only with macro), LOAD.
REQ-015 IDLE: frame_start=1 -> SHIFT; bit counter cleared to 0.
REQ-016 If bit_valid=1 in the same cycle as frame_start, that bit SHALL be captured as bit 0 and the counter SHALL become 1.
REQ-017 SHIFT: each bit_valid SHALL shift serial_in into the shift register per MSB_FIRST and increment the counter by 1.
REQ-018 SHIFT: bit_valid while counter==NUM_BITS SHALL capture the final bit and then go to PARITY if the macro is defined, otherwise to LOAD.
REQ-019 LOAD SHALL last exactly one cycle: word_load=1, word_out=shift register; next state IDLE.
REQ-020 word_out SHALL update only on entry to LOAD and hold its value at all other times.
REQ-021 Latency SHALL be exactly 1 cycle from the last data bit's bit_valid (or parity bit's bit_valid) to word_load=1.
REQ-022 frame_start in SHIFT or PARITY SHALL abort the partial word, set frame_err, clear the counter, and stay in or return to SHIFT; the REQ-016 capture rule applies.
REQ-023 frame_start in LOAD SHALL not suppress word_load; the FSM SHALL go to SHIFT instead of IDLE.
REQ-024 bit_valid in IDLE without frame_start SHALL be ignored.
REQ-025 err_clear SHALL clear frame_err and parity_err on the next edge; a simultaneous set SHALL win over the clear.
REQ-026 The counter SHALL be wide enough for NUM_BITS and SHALL never wrap within a word.

Reset
REQ-027 While n_rst=0: state=IDLE, counter=0, shift register=0, word_out=0, word_load=0, busy=0, frame_err=0, parity_err=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word with no word_load pulse.

Configuration
REQ-029 Macro WORD_PARITY_EN SHALL control parity support.
REQ-030 With WORD_PARITY_EN defined: after the data bits, one more bit_valid SHALL carry an even-parity bit.
REQ-031 With WORD_PARITY_EN defined: a mismatch SHALL set parity_err; LOAD and word_load SHALL still occur.
REQ-032 Without WORD_PARITY_EN: the PARITY state SHALL not exist, parity_err SHALL be constant 0, and SHIFT SHALL go directly to LOAD.

Verification
REQ-033 Basic MSB_FIRST word: frame_start, then 12 bits of 0xA5C MSB-first -> word_out=0xA5C, word_load high exactly 1 cycle, 1 cycle after the 12th strobe.
REQ-034 LSB-first word: MSB_FIRST=0, stream 0x123 LSB-first -> word_out=0x123.
REQ-035 Abort: frame_start after 5 bits, then a full 0xFFF word -> frame_err=1, one word_load only, word_out=0xFFF.
REQ-036 Parity (WORD_PARITY_EN): 0x001 with parity bit 0 -> parity_err=1 and word_load still pulses; with parity bit 1 -> parity_err stays 0.
REQ-037 Reset mid-word: n_rst low after 7 bits -> all outputs 0, no word_load; the next full word 0x0F0 assembles correctly.
REQ-038 Edge cases: frame_start coincident with bit_valid (serial_in=1) -> bit counted as bit 0; err_clear coincident with a new abort -> frame_err stays 1.

Source files
------------

// File: rtl/rx_word_assembler.sv
// Serial-to-parallel word assembler: collects NUM_BITS+1 strobed bits into a word
// and pulses word_load for one cycle. Optional even-parity bit via `WORD_PARITY_EN.
module rx_word_assembler #(
   parameter int NUM_BITS  = 11,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                serial_in,
   input  logic                bit_valid,
   input  logic                frame_start,
   input  logic                err_clear,
   output logic [NUM_BITS:0]   word_out,
   output logic                word_load,
   output logic                busy,
   output logic                frame_err,
   output logic                parity_err
);

   localparam int W  = NUM_BITS + 1;
   localparam int CW = (NUM_BITS < 1) ? 1 : $clog2(NUM_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
`ifdef WORD_PARITY_EN
      PARITY,
`endif
      LOAD
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    sreg, sreg_nxt;
   logic [W-1:0]    shift_cur, first_bit;
   logic            ferr_set;
`ifdef WORD_PARITY_EN
   logic            perr_set;
`endif

   // first_bit is the register image after a frame_start that also carries a bit
   always_comb begin
      if (MSB_FIRST) begin
         shift_cur = {sreg[W-2:0], serial_in};
         first_bit = {{(W-1){1'b0}}, serial_in};
      end else begin
         shift_cur = {serial_in, sreg[W-1:1]};
         first_bit = {serial_in, {(W-1){1'b0}}};
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      ferr_set  = 1'b0;
`ifdef WORD_PARITY_EN
      perr_set  = 1'b0;
`endif
      if (frame_start) begin
         state_nxt = SHIFT;
`ifdef WORD_PARITY_EN
         ferr_set  = (state == SHIFT) || (state == PARITY);
`else
         ferr_set  = (state == SHIFT);
`endif
         if (bit_valid) begin
            sreg_nxt = first_bit;
            cnt_nxt  = CW'(1);
         end else begin
            sreg_nxt = '0;
            cnt_nxt  = '0;
         end
      end else begin
         case (state)
            IDLE: ;
            SHIFT: begin
               if (bit_valid) begin
                  sreg_nxt = shift_cur;
                  // counter is cleared on the final bit so it never wraps
                  if (cnt == CW'(NUM_BITS)) begin
                     cnt_nxt = '0;
`ifdef WORD_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = LOAD;
`endif
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
            end
`ifdef WORD_PARITY_EN
            PARITY: begin
               if (bit_valid) begin
                  perr_set  = ((^sreg) != serial_in);
                  state_nxt = LOAD;
               end
            end
`endif
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sreg      <= '0;
         word_out  <= '0;
         frame_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sreg  <= sreg_nxt;
         if (state_nxt == LOAD) begin
            word_out <= sreg_nxt;
         end
         if (ferr_set) begin
            frame_err <= 1'b1;
         end else if (err_clear) begin
            frame_err <= 1'b0;
         end
      end
   end

`ifdef WORD_PARITY_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         parity_err <= 1'b0;
      end else if (perr_set) begin
         parity_err <= 1'b1;
      end else if (err_clear) begin
         parity_err <= 1'b0;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   assign word_load = (state == LOAD);
   assign busy      = (state != IDLE);

endmodule
